// File: rtl/rf_pkg.sv
// Shared definitions for the scoreboarded register file.
// Holds the default geometry, the stack-pointer reset value, the derived
// index and counter widths, and the scoreboard counter-update encoding.
package rf_pkg;

  localparam int          RF_XLEN     = 32;
  localparam int          RF_NREGS    = 32;
  localparam int          RF_SP_IDX   = 2;
  localparam logic [31:0] RF_SP_INIT  = 32'h2ffc;
  localparam int          RF_MAX_PEND = 3;

  localparam int RF_AW = $clog2(RF_NREGS);
  localparam int RF_CW = $clog2(RF_MAX_PEND + 1);

  // Per-register counter action for one clock edge.
  typedef enum logic [1:0] {
    CNT_HOLD,
    CNT_INC,
    CNT_DEC
  } cnt_op_e;

endpackage

// File: rtl/rf_scoreboard.sv
// Pending-write scoreboard.
// One saturating counter per register tracks in-flight writes (incremented on
// issue, decremented on writeback). Produces busy_vec, the sticky overflow
// flag and the decode hazard_stall for the two source operands.
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   rs1/rs2, rs*_use      decode source indices and their use flags
//   rd, write_enable      writeback index and strobe
//   issue_valid, issue_rd issuing instruction and its destination
//   hazard_stall          decode must stall (combinational)
//   busy_vec              bit i set while register i has pending writes
//   sb_overflow           sticky: an issue hit a saturated counter
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter int NREGS    = RF_NREGS,
  parameter int AW       = $clog2(NREGS),
  parameter int MAX_PEND = RF_MAX_PEND,
  parameter int CW       = $clog2(MAX_PEND + 1),
  parameter int BYPASS   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [AW-1:0]    rs1,
  input  logic [AW-1:0]    rs2,
  input  logic             rs1_use,
  input  logic             rs2_use,
  input  logic [AW-1:0]    rd,
  input  logic             write_enable,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_rd,
  output logic             hazard_stall,
  output logic [NREGS-1:0] busy_vec,
  output logic             sb_overflow
);

  logic [NREGS-1:0][CW-1:0] cnt_flat;
  logic [NREGS-1:0]         ovf_hit;
  logic                     sb_overflow_q;

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_cnt
      if (gi == 0) begin : g_zero
        // x0 is never tracked.
        assign cnt_flat[gi] = '0;
        assign ovf_hit[gi]  = 1'b0;
      end else begin : g_reg
        logic          inc;
        logic          dec;
        cnt_op_e       op;
        logic [CW-1:0] cnt_q;
        logic [CW-1:0] cnt_d;
        logic          ovf;

        assign inc = issue_valid  && (issue_rd == AW'(gi));
        assign dec = write_enable && (rd == AW'(gi));

        always_comb begin
          op    = CNT_HOLD;
          cnt_d = cnt_q;
          ovf   = 1'b0;
          // Issue and writeback to the same register cancel out.
          if (inc && !dec) begin
            op = CNT_INC;
          end else if (dec && !inc) begin
            op = CNT_DEC;
          end
          case (op)
            CNT_INC: begin
              if (cnt_q == CW'(MAX_PEND)) ovf = 1'b1;
              else                        cnt_d = cnt_q + CW'(1);
            end
            CNT_DEC: begin
              // Unscoreboarded writes (cnt==0) leave the counter at zero.
              if (cnt_q != '0) cnt_d = cnt_q - CW'(1);
            end
            default: ;
          endcase
        end

        always_ff @(posedge clk) begin
          if (reset) cnt_q <= '0;
          else       cnt_q <= cnt_d;
        end

        assign cnt_flat[gi] = cnt_q;
        assign ovf_hit[gi]  = ovf;
      end
      assign busy_vec[gi] = (cnt_flat[gi] != '0);
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) sb_overflow_q <= 1'b0;
    else       sb_overflow_q <= sb_overflow_q | (|ovf_hit);
  end
  assign sb_overflow = sb_overflow_q;

  // A source whose last pending write is being written back right now is
  // satisfied through the bypass path, so it does not stall.
  logic rs1_busy;
  logic rs2_busy;
  logic rs1_last;
  logic rs2_last;

  assign rs1_last = (BYPASS != 0) && write_enable && (rd == rs1) && (cnt_flat[rs1] == CW'(1));
  assign rs2_last = (BYPASS != 0) && write_enable && (rd == rs2) && (cnt_flat[rs2] == CW'(1));
  assign rs1_busy = (cnt_flat[rs1] != '0) && !rs1_last;
  assign rs2_busy = (cnt_flat[rs2] != '0) && !rs2_last;

  assign hazard_stall = (rs1_use && rs1_busy) || (rs2_use && rs2_busy);

endmodule

// File: rtl/scoreboard_register_file.sv
// Parametrised register file with optional writeback bypass and a
// pending-write scoreboard for RAW hazard detection in decode.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   rs1, rs2, rs1_use, rs2_use decode read indices and use flags
//   rs1_dout, rs2_dout         combinational read data
//   rd, rd_din, write_enable   writeback port
//   issue_valid, issue_rd      issuing instruction destination
//   hazard_stall               decode stall request
//   busy_vec, sb_overflow      scoreboard status
//   print_reg                  flattened register contents, reg i at [i*XLEN +: XLEN]
module scoreboard_register_file
  import rf_pkg::*;
#(
  parameter int              XLEN     = RF_XLEN,
  parameter int              NREGS    = RF_NREGS,
  parameter int              AW       = $clog2(NREGS),
  parameter int              SP_IDX   = RF_SP_IDX,
  parameter logic [XLEN-1:0] SP_INIT  = XLEN'(RF_SP_INIT),
  parameter int              BYPASS   = 1,
  parameter int              MAX_PEND = RF_MAX_PEND,
  parameter int              CW       = $clog2(MAX_PEND + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [AW-1:0]         rs1,
  input  logic [AW-1:0]         rs2,
  input  logic                  rs1_use,
  input  logic                  rs2_use,
  output logic [XLEN-1:0]       rs1_dout,
  output logic [XLEN-1:0]       rs2_dout,
  input  logic [AW-1:0]         rd,
  input  logic [XLEN-1:0]       rd_din,
  input  logic                  write_enable,
  input  logic                  issue_valid,
  input  logic [AW-1:0]         issue_rd,
  output logic                  hazard_stall,
  output logic [NREGS-1:0]      busy_vec,
  output logic                  sb_overflow,
  output logic [NREGS*XLEN-1:0] print_reg
);

  logic [XLEN-1:0] rf_q [NREGS];
  logic            wr_live;

  assign wr_live = write_enable && (rd != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) begin
        rf_q[i] <= (i == SP_IDX && i != 0) ? SP_INIT : '0;
      end
    end else if (wr_live) begin
      rf_q[rd] <= rd_din;
    end
  end

  always_comb begin
    rs1_dout = (rs1 == '0) ? '0 : rf_q[rs1];
    rs2_dout = (rs2 == '0) ? '0 : rf_q[rs2];
    if (BYPASS != 0 && wr_live && rd == rs1) rs1_dout = rd_din;
    if (BYPASS != 0 && wr_live && rd == rs2) rs2_dout = rd_din;
  end

  genvar gi;
  generate
    for (gi = 0; gi < NREGS; gi++) begin : g_dump
      assign print_reg[gi*XLEN +: XLEN] = rf_q[gi];
    end
  endgenerate

  rf_scoreboard #(
    .NREGS    (NREGS),
    .AW       (AW),
    .MAX_PEND (MAX_PEND),
    .CW       (CW),
    .BYPASS   (BYPASS)
  ) u_sb (
    .clk          (clk),
    .reset        (reset),
    .rs1          (rs1),
    .rs2          (rs2),
    .rs1_use      (rs1_use),
    .rs2_use      (rs2_use),
    .rd           (rd),
    .write_enable (write_enable),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .hazard_stall (hazard_stall),
    .busy_vec     (busy_vec),
    .sb_overflow  (sb_overflow)
  );

endmodule

// File: tb/tb_scoreboard_register_file.sv
module tb_scoreboard_register_file;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1, rs2, rd, issue_rd;
  logic        rs1_use, rs2_use, write_enable, issue_valid;
  logic [31:0] rd_din;

  // BYPASS=1 instance
  logic [31:0]   a_rs1_dout, a_rs2_dout;
  logic          a_stall, a_ovf;
  logic [31:0]   a_busy;
  logic [1023:0] a_print;
  // BYPASS=0 instance
  logic [31:0]   b_rs1_dout, b_rs2_dout;
  logic          b_stall, b_ovf;
  logic [31:0]   b_busy;
  logic [1023:0] b_print;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  scoreboard_register_file #(.BYPASS(1)) u_dut (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rs1_use(rs1_use), .rs2_use(rs2_use),
    .rs1_dout(a_rs1_dout), .rs2_dout(a_rs2_dout), .rd(rd), .rd_din(rd_din),
    .write_enable(write_enable), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .hazard_stall(a_stall), .busy_vec(a_busy), .sb_overflow(a_ovf), .print_reg(a_print)
  );

  scoreboard_register_file #(.BYPASS(0)) u_dut_nb (
    .clk(clk), .reset(reset), .rs1(rs1), .rs2(rs2), .rs1_use(rs1_use), .rs2_use(rs2_use),
    .rs1_dout(b_rs1_dout), .rs2_dout(b_rs2_dout), .rd(rd), .rd_din(rd_din),
    .write_enable(write_enable), .issue_valid(issue_valid), .issue_rd(issue_rd),
    .hazard_stall(b_stall), .busy_vec(b_busy), .sb_overflow(b_ovf), .print_reg(b_print)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Commit one clock edge, then settle past it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    write_enable = 0; issue_valid = 0; rs1_use = 0; rs2_use = 0;
    rd = 0; rd_din = 0; issue_rd = 0;
  endtask

  initial begin
    reset = 1; rs1 = 0; rs2 = 0; idle();
    tick(); tick();
    reset = 0;
    #1;

    // Reset state
    for (int i = 0; i < 32; i++) begin
      rs1 = 5'(i);
      #1;
      chk($sformatf("reset_rd_a x%0d", i), a_rs1_dout, (i == 2) ? 32'h2ffc : 32'h0);
      chk($sformatf("reset_rd_b x%0d", i), b_rs1_dout, (i == 2) ? 32'h2ffc : 32'h0);
    end
    chk("reset_busy", a_busy, 32'h0);
    chk("reset_ovf", {31'b0, a_ovf}, 32'h0);
    chk("reset_stall", {31'b0, a_stall}, 32'h0);
    $display("[TB] reset: 32 registers read back");

    // Register 0: write and issue are both ignored
    rs1 = 0; rs1_use = 1; rd = 0; rd_din = 32'hDEAD; write_enable = 1;
    issue_valid = 1; issue_rd = 0;
    #1;
    chk("x0_bypass", a_rs1_dout, 32'h0);
    chk("x0_stall_same", {31'b0, a_stall}, 32'h0);
    tick(); idle();
    #1;
    chk("x0_read", a_rs1_dout, 32'h0);
    chk("x0_busy", a_busy, 32'h0);
    chk("x0_dump", a_print[31:0], 32'h0);
    $display("[TB] x0: write 0xdead + issue dropped");

    // Bypass vs. no bypass
    rs1 = 5; rd = 5; rd_din = 32'h1234; write_enable = 1;
    #1;
    chk("byp_same_cycle", a_rs1_dout, 32'h1234);
    chk("nobyp_old", b_rs1_dout, 32'h0);
    tick(); idle();
    #1;
    chk("byp_next", a_rs1_dout, 32'h1234);
    chk("nobyp_next", b_rs1_dout, 32'h1234);
    chk("dump_x5", a_print[5*32 +: 32], 32'h1234);
    $display("[TB] write x5=0x1234 bypass checked");

    // Double issue of x7
    issue_valid = 1; issue_rd = 7;
    tick(); tick();
    idle(); rs2 = 7; rs2_use = 1;
    #1;
    chk("dbl_stall", {31'b0, a_stall}, 32'h1);
    chk("dbl_busy", a_busy, 32'h80);
    rd = 7; rd_din = 32'h77; write_enable = 1;
    #1;
    chk("dbl_wb1_stall", {31'b0, a_stall}, 32'h1);
    tick();
    rd_din = 32'h78;
    #1;
    chk("dbl_wb2_stall", {31'b0, a_stall}, 32'h0);
    chk("dbl_wb2_stall_nb", {31'b0, b_stall}, 32'h1);
    chk("dbl_wb2_data", a_rs2_dout, 32'h78);
    tick(); idle(); rs2_use = 1;
    #1;
    chk("dbl_done_stall", {31'b0, a_stall}, 32'h0);
    chk("dbl_done_stall_nb", {31'b0, b_stall}, 32'h0);
    chk("dbl_done_busy", a_busy, 32'h0);
    chk("dbl_done_data", b_rs2_dout, 32'h78);
    $display("[TB] x7 issued twice, drained by two writebacks");

    // Simultaneous issue + writeback to x9 with cnt=1
    idle();
    issue_valid = 1; issue_rd = 9;
    tick();
    write_enable = 1; rd = 9; rd_din = 32'h99;
    tick(); idle();
    #1;
    chk("sim_busy", a_busy, 32'h200);
    // Final writeback of x9 alongside an issue of x10: independent updates
    write_enable = 1; rd = 9; rd_din = 32'h9a; issue_valid = 1; issue_rd = 10;
    tick(); idle();
    #1;
    chk("indep_busy", a_busy, 32'h400);
    chk("indep_x9", a_print[9*32 +: 32], 32'h9a);
    // Unscoreboarded write to x11 plus drain of x10
    write_enable = 1; rd = 11; rd_din = 32'hb0b;
    tick();
    rd = 10; rd_din = 32'ha0a;
    tick(); idle();
    #1;
    chk("unsb_busy", a_busy, 32'h0);
    chk("unsb_x11", a_print[11*32 +: 32], 32'hb0b);
    chk("unsb_ovf", {31'b0, a_ovf}, 32'h0);
    $display("[TB] x9 issue+wb, x10/x11 independent updates");

    // Overflow on x3
    rd = 3; rd_din = 32'h33; write_enable = 1;
    tick(); idle();
    issue_valid = 1; issue_rd = 3;
    tick(); tick(); tick();
    #1;
    chk("ovf_before", {31'b0, a_ovf}, 32'h0);
    tick(); idle();
    rs1 = 3; rs1_use = 1;
    #1;
    chk("ovf_set", {31'b0, a_ovf}, 32'h1);
    chk("ovf_busy", a_busy, 32'h8);
    chk("ovf_stall", {31'b0, a_stall}, 32'h1);
    // Two writebacks leave x3 still pending when cnt saturated at 3
    write_enable = 1; rd = 3; rd_din = 32'h34;
    tick(); tick(); idle(); rs1_use = 1;
    #1;
    chk("ovf_cnt3", a_busy, 32'h8);
    chk("ovf_sticky", {31'b0, a_ovf}, 32'h1);
    $display("[TB] x3 issued 4x, overflow flagged");

    // Mid-operation reset dominates concurrent issue and write
    reset = 1; issue_valid = 1; issue_rd = 3; write_enable = 1; rd = 4; rd_din = 32'h44;
    tick();
    reset = 0; idle();
    #1;
    chk("rst2_busy", a_busy, 32'h0);
    chk("rst2_ovf", {31'b0, a_ovf}, 32'h0);
    chk("rst2_x3", a_print[3*32 +: 32], 32'h0);
    chk("rst2_x4", a_print[4*32 +: 32], 32'h0);
    chk("rst2_sp", a_print[2*32 +: 32], 32'h2ffc);
    chk("rst2_nb_x3", b_print[3*32 +: 32], 32'h0);
    chk("rst2_stall", {31'b0, a_stall}, 32'h0);
    $display("[TB] reset mid-operation clears state");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/scoreboard_register_file.md
Name: scoreboard_register_file

Overview:
- Parametrised successor of the single-issue CPU register file, for the pipelined core.
- Adds configurable width, depth and stack-pointer init.
- Adds an optional write-to-read bypass.
- Adds a per-register pending-write scoreboard that decode uses to detect RAW hazards and generate stalls.
- Sits between decode (read and issue side) and writeback (write side).

Parameters:
XLEN, 32, data width of each register
NREGS, 32, number of architectural registers (power of two, at least 2)
AW, $clog2(NREGS), register index width (derived; do not override)
SP_IDX, 2, index of the stack-pointer register
SP_INIT, 32'h2ffc, reset value of register SP_IDX
BYPASS, 1, 1 = same-cycle writeback data is forwarded to the read ports
MAX_PEND, 3, maximum in-flight writes tracked per register
CW, $clog2(MAX_PEND+1), pending-counter width (derived)

Ports:
clk  in  1  clock; all state updates on the rising edge
reset  in  1  synchronous, active-high reset
rs1  in  AW  read index A
rs2  in  AW  read index B
rs1_use  in  1  instruction actually reads rs1
rs2_use  in  1  instruction actually reads rs2
rs1_dout  out  XLEN  read data A (combinational)
rs2_dout  out  XLEN  read data B (combinational)
rd  in  AW  writeback index
rd_din  in  XLEN  writeback data
write_enable  in  1  writeback strobe (RegWrite)
issue_valid  in  1  an instruction writing issue_rd leaves decode this cycle
issue_rd  in  AW  destination of the issuing instruction
hazard_stall  out  1  the decode-stage instruction must stall
busy_vec  out  NREGS  bit i = register i has pending writes
sb_overflow  out  1  sticky error: an issue arrived at a saturated counter
print_reg  out  NREGS*XLEN  flattened register contents for the debug dump; register i at bits [i*XLEN +: XLEN]

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous and active-high.
- Reset values:
  - All registers = 0, except register SP_IDX = SP_INIT.
  - All pending counters = 0.
  - sb_overflow = 0.
  - Reset dominates any write or issue in the same cycle.
- Register 0:
  - Always reads 0.
  - Writes to it are dropped.
  - Issues to it are ignored; busy_vec[0] is always 0.
- Write: on a rising edge with write_enable=1 and rd!=0, rf[rd] <= rd_din. The write lands whether or not the register is pending.
- Read: rs*_dout = rf[rs*], combinational. When BYPASS=1 and write_enable=1 and rd==rs* and rd!=0, rs*_dout = rd_din in the same cycle. When BYPASS=0 the new value is visible the cycle after the write.
- Scoreboard: one CW-bit counter per register, updated on each rising edge.
  - Issue only (issue_valid=1, issue_rd!=0): cnt+1.
  - Writeback only (write_enable=1, rd!=0): cnt-1.
  - Issue and writeback to the same register in one cycle: cnt unchanged.
  - Issue and writeback to different registers: each counter updates independently.
  - Writeback with cnt=0: data is written and cnt stays 0 (unscoreboarded write; not an error).
  - Issue with cnt=MAX_PEND: cnt stays MAX_PEND and sb_overflow is set to 1 until reset.
- busy_vec[i] = (cnt[i] != 0).
- Per-source busy (rsX = rs1 or rs2): rsX_busy = cnt[rsX]!=0, except it is 0 when BYPASS=1 and write_enable=1 and rd==rsX and cnt[rsX]==1 (the last pending write completes now).
- hazard_stall = (rs1_use & rs1_busy) | (rs2_use & rs2_busy). This is combinational; there is no added latency.
- Decode must not assert issue_valid while hazard_stall=1. This block does not check that rule.

Decomposition:
- rf_pkg holds:
  - default XLEN, NREGS, SP_IDX, SP_INIT, MAX_PEND;
  - the clog2-derived AW and CW;
  - an enum for counter update (CNT_HOLD, CNT_INC, CNT_DEC).
- Sub-module rf_scoreboard owns the NREGS pending counters, busy_vec, sb_overflow and the per-source busy logic.
- The top level owns data storage, the bypass mux and print_reg.

Test Plan:
- Reset: hold reset for 2 cycles, then read all indices. Expect rf[2]=32'h2ffc, all others 0, busy_vec=0, sb_overflow=0.
- Register 0: write rd=0, rd_din=32'hDEAD; issue issue_rd=0. Expect rs1=0 reads 0, busy_vec[0]=0, hazard_stall=0.
- Bypass and write: with BYPASS=1, write rd=5, rd_din=32'h1234 while rs1=5. Expect rs1_dout=32'h1234 in the same cycle. With BYPASS=0, expect the old value, then 32'h1234 on the next cycle.
- Double issue:
  - Issue x7 twice, so cnt=2. With rs2=7 and rs2_use=1, expect hazard_stall=1.
  - First writeback: stall stays 1.
  - Second writeback: stall drops to 0 in the same cycle (BYPASS=1).
- Simultaneous issue and writeback: issue x9 and write x9 in one cycle with cnt[9]=1. Expect cnt[9] stays 1 and busy_vec[9]=1.
- Overflow and mid-operation reset:
  - Issue x3 four times with MAX_PEND=3. Expect cnt=3 and sb_overflow=1.
  - Assert reset for 1 cycle. Expect busy_vec=0, sb_overflow=0, rf[3]=0.
